// File: rtl/masked_adder_pkg.sv
// Shared types and defaults for the first-order masked bit-serial adder.
package masked_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } phase_t;

endpackage

// File: rtl/dom_and.sv
// First-order DOM AND gadget: the cross-domain terms are blinded with r and
// all four partial products are registered before the shares are recombined.
module dom_and (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic x0,
    input  logic x1,
    input  logic y0,
    input  logic y1,
    input  logic r,
    output logic z0,
    output logic z1
);

    logic t00_q, t01_q, t10_q, t11_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t00_q <= 1'b0;
            t01_q <= 1'b0;
            t10_q <= 1'b0;
            t11_q <= 1'b0;
        end else if (en) begin
            t00_q <= x0 & y0;
            t01_q <= (x0 & y1) ^ r;
            t10_q <= (x1 & y0) ^ r;
            t11_q <= x1 & y1;
        end
    end

    // Domain k only ever sees its own same-domain term and a registered cross term.
    assign z0 = t00_q ^ t01_q;
    assign z1 = t11_q ^ t10_q;

endmodule

// File: rtl/masked_serial_adder.sv
// Boolean-masked ripple adder, one bit per two cycles (P0 multiplies, P1 commits).
// Optional output refresh with rnd[2] when MASKED_ADD_OUT_REFRESH_EN is defined.
module masked_serial_adder
    import masked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       rnd,
    output logic [WIDTH-1:0] sum0,
    output logic [WIDTH-1:0] sum1,
    output logic             cout0,
    output logic             cout1,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q;
    phase_t           phase_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a0_q, a1_q, b0_q, b1_q;
    logic             c0_q, c1_q;

    logic p0, p1;
    logic ab0, ab1, cp0, cp1;
    logic c0_new, c1_new;
    logic dom_en;
    logic rf;

    // Half-sum per domain is linear, so it never mixes shares.
    assign p0 = a0_q[idx_q] ^ b0_q[idx_q];
    assign p1 = a1_q[idx_q] ^ b1_q[idx_q];

    assign dom_en = (state_q == CALC) && (phase_q == P0);

    dom_and u_and_ab (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (dom_en),
        .x0   (a0_q[idx_q]),
        .x1   (a1_q[idx_q]),
        .y0   (b0_q[idx_q]),
        .y1   (b1_q[idx_q]),
        .r    (rnd[0]),
        .z0   (ab0),
        .z1   (ab1)
    );

    dom_and u_and_cp (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (dom_en),
        .x0   (c0_q),
        .x1   (c1_q),
        .y0   (p0),
        .y1   (p1),
        .r    (rnd[1]),
        .z0   (cp0),
        .z1   (cp1)
    );

    assign c0_new = ab0 ^ cp0;
    assign c1_new = ab1 ^ cp1;

`ifdef MASKED_ADD_OUT_REFRESH_EN
    assign rf = rnd[2];
`else
    logic unused_rnd2;
    assign unused_rnd2 = rnd[2];
    assign rf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= P0;
            idx_q     <= '0;
            a0_q      <= '0;
            a1_q      <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            sum0      <= '0;
            sum1      <= '0;
            cout0     <= 1'b0;
            cout1     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a0_q     <= a0;
                        a1_q     <= a1;
                        b0_q     <= b0;
                        b1_q     <= b1;
                        c0_q     <= 1'b0;
                        c1_q     <= 1'b0;
                        idx_q    <= '0;
                        phase_q  <= P0;
                        in_ready <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (phase_q == P0) begin
                        phase_q <= P1;
                    end else begin
                        phase_q     <= P0;
                        sum0[idx_q] <= p0 ^ c0_q ^ rf;
                        sum1[idx_q] <= p1 ^ c1_q ^ rf;
                        c0_q        <= c0_new;
                        c1_q        <= c1_new;
                        if (idx_q == LAST_IDX) begin
                            cout0     <= c0_new ^ rf;
                            cout1     <= c1_new ^ rf;
                            out_valid <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
